// File: rtl/sym_restore_if.sv
// -----------------------------------------------------------------------------
// sym_restore_if
//   Handshake bundle around the symmetry-restore block. It carries four
//   valid/ready channels:
//     in   : signed sample from the upstream stream.
//     core : folded magnitude going to the evaluation core.
//     res  : signed result returning from the core.
//     out  : restored signed result going to the downstream consumer.
//   It also carries the sticky err flag. When SYM_RESTORE_SAT_EN is defined it
//   carries the sat pulse as well.
//
//   Modports:
//     master : environment side. It drives the in/res channels and the core/out
//              ready signals.
//     slave  : block side (sym_restore).
//
//   Parameter W is the sample width. It must equal M+N of the attached block.
// -----------------------------------------------------------------------------
interface sym_restore_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  logic         core_valid;
  logic         core_ready;
  logic [W-1:0] core_data;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  logic         err;
`ifdef SYM_RESTORE_SAT_EN
  logic         sat;

  modport master (
    output in_valid, in_data, core_ready, res_valid, res_data, out_ready,
    input  in_ready, core_valid, core_data, res_ready, out_valid, out_data,
           err, sat
  );

  modport slave (
    input  in_valid, in_data, core_ready, res_valid, res_data, out_ready,
    output in_ready, core_valid, core_data, res_ready, out_valid, out_data,
           err, sat
  );
`else
  modport master (
    output in_valid, in_data, core_ready, res_valid, res_data, out_ready,
    input  in_ready, core_valid, core_data, res_ready, out_valid, out_data,
           err
  );

  modport slave (
    input  in_valid, in_data, core_ready, res_valid, res_data, out_ready,
    output in_ready, core_valid, core_data, res_ready, out_valid, out_data,
           err
  );
`endif
endinterface

// File: rtl/sym_restore.sv
// -----------------------------------------------------------------------------
// sym_restore
//   Return path of the symmetry fold. The block wraps a variable-latency,
//   in-order evaluation core.
//
//   Input side: each signed sample is folded to its magnitude, which is issued
//   to the core. The sample's sign is pushed into a small in-order FIFO.
//
//   Output side: when a core result returns, the oldest sign is popped and
//   symmetry is re-applied:
//     even function (FUNC_TYPE=0) : result passes through unchanged.
//     odd function  (FUNC_TYPE=1) : result is negated if the sample was
//                                   negative.
//
//   Ports:
//     clk : rising-edge clock.
//     rst : asynchronous, active-high reset.
//     bus : sym_restore_if.slave, which carries the following:
//       in_valid / in_ready / in_data       : upstream samples.
//       core_valid / core_ready / core_data : magnitude to the core.
//       res_valid / res_ready / res_data    : results from the core.
//       out_valid / out_ready / out_data    : restored results.
//       err                                 : sticky; set when a result
//                                             arrives with no sign in flight.
//       sat                                 : only with SYM_RESTORE_SAT_EN.
//
//   Optional build macro SYM_RESTORE_SAT_EN:
//     When defined, both negations saturate: |MIN| becomes MAX and -MIN becomes
//     MAX. In addition, sat pulses for one cycle alongside the core or out load
//     that saturated.
//     When undefined, both negations wrap, so MIN stays MIN.
// -----------------------------------------------------------------------------
module sym_restore #(
  parameter int M         = 4,
  parameter int N         = 8,
  parameter int FUNC_TYPE = 0,
  parameter int DEPTH     = 4
) (
  input  logic           clk,
  input  logic           rst,
  sym_restore_if.slave   bus
);

  localparam int W  = M + N;
  localparam int AW = $clog2(DEPTH);

  localparam logic [W-1:0]  ONE_W   = W'(1);
  localparam logic [W-1:0]  MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAX_VAL = ~MIN_VAL;
  localparam logic [AW-1:0] ONE_P   = AW'(1);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);

  // Registered state
  logic           core_valid_q;
  logic [W-1:0]   core_data_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic           err_q;
  logic [AW:0]    count;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           sign_mem [DEPTH];

  // Handshake decode
  logic in_ready;
  logic res_ready;
  logic in_xfer;
  logic core_xfer;
  logic res_xfer;
  logic out_xfer;
  logic fifo_empty;
  logic pop;

  // Datapath
  logic [W-1:0] in_neg;
  logic [W-1:0] res_neg;
  logic [W-1:0] core_mag;
  logic [W-1:0] restored;
  logic         pop_sign;
`ifdef SYM_RESTORE_SAT_EN
  logic         in_sat;
  logic         res_sat;
  logic         sat_q;
`endif

  assign fifo_empty = (count == '0);

  // Holding rst in the ready term keeps upstream stalled for the whole reset
  // pulse. Without it, the cleared registers alone would raise in_ready.
  assign in_ready  = !rst && (!core_valid_q || bus.core_ready) && (count != FULL_C);
  assign res_ready = !out_valid_q || bus.out_ready;

  assign in_xfer   = bus.in_valid  && in_ready;
  assign core_xfer = core_valid_q  && bus.core_ready;
  assign res_xfer  = bus.res_valid && res_ready;
  assign out_xfer  = out_valid_q   && bus.out_ready;
  assign pop       = res_xfer && !fifo_empty;

  assign in_neg  = ~bus.in_data  + ONE_W;
  assign res_neg = ~bus.res_data + ONE_W;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    core_mag = bus.in_data[W-1] ? in_neg : bus.in_data;
    pop_sign = fifo_empty ? 1'b0 : sign_mem[rd_ptr];
    restored = bus.res_data;
`ifdef SYM_RESTORE_SAT_EN
    in_sat  = 1'b0;
    res_sat = 1'b0;
    if (bus.in_data == MIN_VAL) begin
      core_mag = MAX_VAL;
      in_sat   = 1'b1;
    end
`endif
    if (FUNC_TYPE == 1 && pop_sign) begin
      restored = res_neg;
`ifdef SYM_RESTORE_SAT_EN
      if (bus.res_data == MIN_VAL) begin
        restored = MAX_VAL;
        res_sat  = 1'b1;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every register
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      err_q        <= 1'b0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
`ifdef SYM_RESTORE_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      // Issue stage
      if (in_xfer) begin
        core_data_q  <= core_mag;
        core_valid_q <= 1'b1;
      end else if (core_xfer) begin
        core_valid_q <= 1'b0;
      end

      // Result stage
      if (res_xfer) begin
        out_data_q  <= restored;
        out_valid_q <= 1'b1;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end

      // A result with no sign in flight means the core and this block have
      // lost step. Flag it and keep the count pinned at zero.
      if (res_xfer && fifo_empty) begin
        err_q <= 1'b1;
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      if (in_xfer) wr_ptr <= wr_ptr + ONE_P;
      if (pop)     rd_ptr <= rd_ptr + ONE_P;

      case ({in_xfer, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase

`ifdef SYM_RESTORE_SAT_EN
      sat_q <= (in_xfer && in_sat) || (res_xfer && res_sat);
`endif
    end
  end

  // NOTE: the sign storage has no reset. Reads are gated by count, which is
  // reset, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      sign_mem[wr_ptr] <= bus.in_data[W-1];
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.core_valid = core_valid_q;
  assign bus.core_data  = core_data_q;
  assign bus.res_ready  = res_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.err        = err_q;
`ifdef SYM_RESTORE_SAT_EN
  assign bus.sat        = sat_q;
`endif

endmodule

// File: tb/tb_sym_restore.sv
// -----------------------------------------------------------------------------
// tb_sym_restore
//   Directed bench for sym_restore. Two instances are driven with identical
//   stimulus:
//     u_odd  : FUNC_TYPE=1
//     u_even : FUNC_TYPE=0
//   Both instances use M=4, N=8 (W=12) and DEPTH=4. Every expected value is
//   written out by hand.
// -----------------------------------------------------------------------------
module tb_sym_restore;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         core_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         out_ready;

  int n_cmp = 0;
  int n_err = 0;

  sym_restore_if #(.W(W)) bo ();
  sym_restore_if #(.W(W)) be ();

  assign bo.in_valid   = in_valid;
  assign bo.in_data    = in_data;
  assign bo.core_ready = core_ready;
  assign bo.res_valid  = res_valid;
  assign bo.res_data   = res_data;
  assign bo.out_ready  = out_ready;

  assign be.in_valid   = in_valid;
  assign be.in_data    = in_data;
  assign be.core_ready = core_ready;
  assign be.res_valid  = res_valid;
  assign be.res_data   = res_data;
  assign be.out_ready  = out_ready;

  sym_restore #(.M(4), .N(8), .FUNC_TYPE(1), .DEPTH(4)) u_odd (
    .clk (clk),
    .rst (rst),
    .bus (bo.slave)
  );

  sym_restore #(.M(4), .N(8), .FUNC_TYPE(0), .DEPTH(4)) u_even (
    .clk (clk),
    .rst (rst),
    .bus (be.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] fill_vals [4];
  logic [W-1:0] drain_res [4];
  logic [W-1:0] drain_odd [4];

  initial begin
    fill_vals = '{12'hFFF, 12'h002, 12'hFFD, 12'h004};
    drain_res = '{12'h00A, 12'h00B, 12'h00C, 12'h00D};
    // The signs left in flight are -3, +4, +5 and +6, so only the first
    // drained result is negated by the odd instance.
    drain_odd = '{12'hFF6, 12'h00B, 12'h00C, 12'h00D};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    core_ready = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    out_ready  = 1'b1;

    // ---------------- reset state ----------------
    #3;
    check("rst_in_ready",   32'(bo.in_ready),   32'h0);
    check("rst_core_valid", 32'(bo.core_valid), 32'h0);
    check("rst_core_data",  32'(bo.core_data),  32'h0);
    check("rst_out_valid",  32'(bo.out_valid),  32'h0);
    check("rst_out_data",   32'(bo.out_data),   32'h0);
    check("rst_err",        32'(bo.err),        32'h0);
    tick();
    tick();
    rst = 1'b0;

    // ---------------- odd: -300 -> 300, 150 -> -150 ----------------
    in_valid = 1'b1;
    in_data  = 12'hED4;
    tick();
    in_valid = 1'b0;
    check("neg_core_valid",  32'(bo.core_valid), 32'h1);
    check("neg_core_data",   32'(bo.core_data),  32'h12C);
    check("stall_in_ready",  32'(bo.in_ready),   32'h0);
    core_ready = 1'b1;
    tick();
    check("core_drop_valid", 32'(bo.core_valid), 32'h0);
    res_valid = 1'b1;
    res_data  = 12'h096;
    #1;
    check("res_ready_idle",  32'(bo.res_ready),  32'h1);
    tick();
    res_valid = 1'b0;
    check("odd_out_valid",   32'(bo.out_valid),  32'h1);
    check("odd_out_neg",     32'(bo.out_data),   32'hF6A);
    check("even_out_neg",    32'(be.out_data),   32'h096);
    tick();
    check("out_drop_valid",  32'(bo.out_valid),  32'h0);

    // ---------------- +300 -> 300, 150 -> 150 ----------------
    in_valid = 1'b1;
    in_data  = 12'h12C;
    tick();
    in_valid = 1'b0;
    check("pos_core_data_odd",  32'(bo.core_data), 32'h12C);
    check("pos_core_data_even", 32'(be.core_data), 32'h12C);
    tick();
    res_valid = 1'b1;
    res_data  = 12'h096;
    tick();
    res_valid = 1'b0;
    check("odd_out_pos",  32'(bo.out_data), 32'h096);
    check("even_out_pos", 32'(be.out_data), 32'h096);
    tick();

    // ---------------- fill to DEPTH, concurrent push/pop, pointer wrap ----------------
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = fill_vals[i];
      #1;
      check($sformatf("fill_in_ready_%0d", i), 32'(bo.in_ready), 32'h1);
      tick();
    end
    check("full_in_ready",  32'(bo.in_ready),  32'h0);
    check("full_core_data", 32'(bo.core_data), 32'h004);
    in_valid = 1'b0;
    tick();
    check("full_in_ready_idle", 32'(bo.in_ready), 32'h0);
    res_valid = 1'b1;
    res_data  = 12'h007;
    tick();
    res_valid = 1'b0;
    check("pop1_odd",      32'(bo.out_data), 32'hFF9);
    check("pop1_even",     32'(be.out_data), 32'h007);
    check("pop1_in_ready", 32'(bo.in_ready), 32'h1);
    in_valid  = 1'b1;
    in_data   = 12'h005;
    res_valid = 1'b1;
    res_data  = 12'h009;
    tick();
    check("pushpop_out",      32'(bo.out_data), 32'h009);
    check("pushpop_in_ready", 32'(bo.in_ready), 32'h1);
    in_data   = 12'h006;
    res_valid = 1'b0;
    tick();
    in_valid = 1'b0;
    check("refull_in_ready", 32'(bo.in_ready), 32'h0);
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_data = drain_res[i];
      tick();
      check($sformatf("drain_odd_%0d", i),  32'(bo.out_data), 32'(drain_odd[i]));
      check($sformatf("drain_even_%0d", i), 32'(be.out_data), 32'(drain_res[i]));
    end
    res_valid = 1'b0;
    tick();
    check("drain_err",       32'(bo.err),       32'h0);
    check("drain_in_ready",  32'(bo.in_ready),  32'h1);
    check("drain_out_valid", 32'(bo.out_valid), 32'h0);

    // ---------------- downstream backpressure ----------------
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    tick();
    in_data  = 12'hFFE;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    res_valid = 1'b1;
    res_data  = 12'h014;
    tick();
    check("bp_out_valid", 32'(bo.out_valid), 32'h1);
    check("bp_out_first", 32'(bo.out_data),  32'hFEC);
    check("bp_res_ready", 32'(bo.res_ready), 32'h0);
    res_data = 12'h015;
    tick();
    tick();
    check("bp_hold_data",      32'(bo.out_data),  32'hFEC);
    check("bp_hold_valid",     32'(bo.out_valid), 32'h1);
    check("bp_hold_res_ready", 32'(bo.res_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    check("bp_release_res_ready", 32'(bo.res_ready), 32'h1);
    tick();
    check("bp_second_odd",  32'(bo.out_data), 32'hFEB);
    check("bp_second_even", 32'(be.out_data), 32'h015);
    res_valid = 1'b0;
    tick();
    check("bp_done_valid", 32'(bo.out_valid), 32'h0);
    check("bp_done_err",   32'(bo.err),       32'h0);

    // ---------------- most negative value ----------------
    in_valid = 1'b1;
    in_data  = 12'h800;
    tick();
    in_valid = 1'b0;
`ifdef SYM_RESTORE_SAT_EN
    check("min_core_data", 32'(bo.core_data), 32'h7FF);
    check("min_in_sat",    32'(bo.sat),       32'h1);
`else
    check("min_core_data", 32'(bo.core_data), 32'h800);
`endif
    tick();
`ifdef SYM_RESTORE_SAT_EN
    check("min_in_sat_drop", 32'(bo.sat), 32'h0);
`endif
    res_valid = 1'b1;
    res_data  = 12'h800;
    tick();
    res_valid = 1'b0;
`ifdef SYM_RESTORE_SAT_EN
    check("min_out_odd", 32'(bo.out_data), 32'h7FF);
    check("min_res_sat", 32'(bo.sat),      32'h1);
    check("min_even_sat", 32'(be.sat),     32'h0);
`else
    check("min_out_odd", 32'(bo.out_data), 32'h800);
`endif
    check("min_out_even", 32'(be.out_data), 32'h800);
    tick();
`ifdef SYM_RESTORE_SAT_EN
    check("min_res_sat_drop", 32'(bo.sat), 32'h0);
`endif

    // ---------------- async reset mid-operation, then empty pop ----------------
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    tick();
    in_data  = 12'hFFE;
    tick();
    in_data   = 12'hFFD;
    res_valid = 1'b1;
    res_data  = 12'h003;
    tick();
    in_valid  = 1'b0;
    res_valid = 1'b0;
    check("pre_rst_core_valid", 32'(bo.core_valid), 32'h1);
    check("pre_rst_out_valid",  32'(bo.out_valid),  32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_core_valid", 32'(bo.core_valid), 32'h0);
    check("async_out_valid",  32'(bo.out_valid),  32'h0);
    check("async_err",        32'(bo.err),        32'h0);
    check("async_in_ready",   32'(bo.in_ready),   32'h0);
    check("async_out_data",   32'(bo.out_data),   32'h0);
    tick();
    rst = 1'b0;
    res_valid = 1'b1;
    res_data  = 12'h005;
    tick();
    res_valid = 1'b0;
    check("empty_out_odd",   32'(bo.out_data),  32'h005);
    check("empty_out_even",  32'(be.out_data),  32'h005);
    check("empty_out_valid", 32'(bo.out_valid), 32'h1);
    check("empty_err",       32'(bo.err),       32'h1);
    tick();
    tick();
    check("sticky_err",      32'(bo.err),      32'h1);
    check("empty_in_ready",  32'(bo.in_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
